// File: rtl/disp2_pkg.sv
// Shared definitions for the two-output dispatcher flow controller:
// FSM encodings, threshold defaults and the saturating counter helper.
package disp2_pkg;

    localparam int DEF_DEPTH_W = 3;
    localparam int DEF_AF      = 3;
    localparam int DEF_AE      = 1;
    localparam int COUNT_W     = 8;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/disp2_flow_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant when ready, pointer
// moves to the other requester after every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       ready_i,
    output logic [1:0] gnt_o
);

    // ptr_q = 0 favours requester 0 when both request.
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (ready_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/disp2_flow_ctrl.sv
// Flow control for the dispatcher's two output FIFOs: write gating from
// almost-full, round-robin read grants to one shared downstream port.
module disp2_flow_ctrl
    import disp2_pkg::*;
#(
    parameter int DEPTH_W = DEF_DEPTH_W,
    parameter int AF_DEF  = DEF_AF,
    parameter int AE_DEF  = DEF_AE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic [DEPTH_W-1:0] umbral_af_in,
    input  logic [DEPTH_W-1:0] umbral_ae_in,
    input  logic               valid_in,
    input  logic               empty_f1,
    input  logic               empty_f2,
    input  logic               almost_full_f1,
    input  logic               almost_full_f2,
    input  logic               dest_ready,
    output logic               write,
    output logic               read_f1,
    output logic               read_f2,
    output logic               pause,
    output logic [DEPTH_W-1:0] umbral_af,
    output logic [DEPTH_W-1:0] umbral_ae,
    output logic [1:0]         state,
    output logic               idle,
    output logic [COUNT_W-1:0] count_f1,
    output logic [COUNT_W-1:0] count_f2
);

    state_e                     state_q, state_d;
    logic   [DEPTH_W-1:0]       af_q, af_d, ae_q, ae_d;
    logic                       pause_q;
    logic   [1:0]               gnt;
    logic   [1:0][COUNT_W-1:0]  count_w;
    logic                       both_empty;

    assign both_empty = empty_f1 & empty_f2;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = both_empty ? ST_IDLE : ST_ACTIVE;
            ST_IDLE: begin
                if (init)             state_d = ST_INIT;
                else if (!both_empty) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)             state_d = ST_INIT;
                else if (both_empty)  state_d = ST_IDLE;
            end
            default:   state_d = ST_RESET;
        endcase
    end

    // Thresholds track the inputs for as long as the FSM sits in INIT.
    always_comb begin
        af_d = af_q;
        ae_d = ae_q;
        if (state_q == ST_INIT) begin
            af_d = umbral_af_in;
            ae_d = umbral_ae_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET;
            af_q    <= DEPTH_W'(AF_DEF);
            ae_q    <= DEPTH_W'(AE_DEF);
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            pause_q <= almost_full_f1 | almost_full_f2;
        end
    end

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (reset),
        .req_i   ({~empty_f2, ~empty_f1}),
        .ready_i (dest_ready & (state_q == ST_ACTIVE)),
        .gnt_o   (gnt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [COUNT_W-1:0] cnt_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                end else if (gnt[gi]) begin
                    cnt_q <= sat_inc(cnt_q);
                end
            end

            assign count_w[gi] = cnt_q;
        end
    endgenerate

    assign read_f1   = gnt[0];
    assign read_f2   = gnt[1];
    assign pause     = pause_q;
    assign write     = valid_in & ~pause_q &
                       ((state_q == ST_IDLE) | (state_q == ST_ACTIVE));
    assign umbral_af = af_q;
    assign umbral_ae = ae_q;
    assign state     = state_q;
    assign idle      = (state_q == ST_IDLE);
    assign count_f1  = count_w[0];
    assign count_f2  = count_w[1];

endmodule

// File: tb/tb_disp2_flow_ctrl.sv
// Directed bench for disp2_flow_ctrl; a small reference model pushes the
// expected grant per cycle into a queue that is popped at the check point.
module tb_disp2_flow_ctrl;

    logic       clk = 1'b0;
    logic       reset, init, valid_in, empty_f1, empty_f2;
    logic       almost_full_f1, almost_full_f2, dest_ready;
    logic [2:0] umbral_af_in, umbral_ae_in;
    logic       write, read_f1, read_f2, pause, idle;
    logic [2:0] umbral_af, umbral_ae;
    logic [1:0] state;
    logic [7:0] count_f1, count_f2;

    int tests = 0;
    int fails = 0;

    logic [1:0] exp_q[$];
    logic [1:0] m_st;
    logic       m_ptr, m_pause;
    int         m_c1, m_c2;
    logic [2:0] m_af, m_ae;

    disp2_flow_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .init           (init),
        .umbral_af_in   (umbral_af_in),
        .umbral_ae_in   (umbral_ae_in),
        .valid_in       (valid_in),
        .empty_f1       (empty_f1),
        .empty_f2       (empty_f2),
        .almost_full_f1 (almost_full_f1),
        .almost_full_f2 (almost_full_f2),
        .dest_ready     (dest_ready),
        .write          (write),
        .read_f1        (read_f1),
        .read_f2        (read_f2),
        .pause          (pause),
        .umbral_af      (umbral_af),
        .umbral_ae      (umbral_ae),
        .state          (state),
        .idle           (idle),
        .count_f1       (count_f1),
        .count_f2       (count_f2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 2'd0; m_ptr = 1'b0; m_pause = 1'b0;
        m_c1 = 0; m_c2 = 0; m_af = 3'd3; m_ae = 3'd1;
    endtask

    // One clock cycle: inputs already driven at posedge+1.
    task automatic cycle();
        logic [1:0] eg;
        logic       be;
        eg = 2'b00;
        if (m_st == 2'd3 && dest_ready) begin
            if (!empty_f1 && !empty_f2) eg = m_ptr ? 2'b10 : 2'b01;
            else if (!empty_f1)         eg = 2'b01;
            else if (!empty_f2)         eg = 2'b10;
        end
        exp_q.push_back(eg);
        @(negedge clk);
        check("grant", {30'd0, read_f2, read_f1}, {30'd0, exp_q.pop_front()});
        check("state", {30'd0, state}, {30'd0, m_st});
        check("idle", {31'd0, idle}, {31'd0, (m_st == 2'd2)});
        check("pause", {31'd0, pause}, {31'd0, m_pause});
        check("write", {31'd0, write}, {31'd0, valid_in & ~m_pause & m_st[1]});
        if (reset) begin
            model_reset();
        end else begin
            be = empty_f1 & empty_f2;
            if (eg[0] && m_c1 < 255) m_c1++;
            if (eg[1] && m_c2 < 255) m_c2++;
            if (eg != 2'b00) m_ptr = eg[0];
            m_pause = almost_full_f1 | almost_full_f2;
            if (m_st == 2'd1) begin
                m_af = umbral_af_in;
                m_ae = umbral_ae_in;
            end
            if (m_st == 2'd0)       m_st = 2'd1;
            else if (m_st == 2'd1)  m_st = init ? 2'd1 : (be ? 2'd2 : 2'd3);
            else                    m_st = init ? 2'd1 : (be ? 2'd2 : 2'd3);
        end
        @(posedge clk);
        #1;
        check("count_f1", {24'd0, count_f1}, m_c1);
        check("count_f2", {24'd0, count_f2}, m_c2);
        check("umbral_af", {29'd0, umbral_af}, {29'd0, m_af});
        check("umbral_ae", {29'd0, umbral_ae}, {29'd0, m_ae});
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; valid_in = 1'b0;
        umbral_af_in = 3'd3; umbral_ae_in = 3'd1;
        empty_f1 = 1'b1; empty_f2 = 1'b1;
        almost_full_f1 = 1'b0; almost_full_f2 = 1'b0; dest_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        $display("[TB] step: reset held");
        cycle(); cycle();

        $display("[TB] step: release reset, RESET->INIT->IDLE");
        reset = 1'b0;
        cycle(); cycle(); cycle();

        $display("[TB] step: load thresholds 5/2 through INIT");
        init = 1'b1; umbral_af_in = 3'd5; umbral_ae_in = 3'd2;
        cycle(); cycle(); cycle();
        init = 1'b0;
        cycle();
        umbral_af_in = 3'd7; umbral_ae_in = 3'd6;
        cycle(); cycle();
        check("umbral_af_loaded", {29'd0, umbral_af}, 32'd5);
        check("umbral_ae_loaded", {29'd0, umbral_ae}, 32'd2);

        $display("[TB] step: both FIFOs non-empty, alternating grants");
        empty_f1 = 1'b0; empty_f2 = 1'b0; dest_ready = 1'b1;
        cycle();
        repeat (6) cycle();
        check("count_f1_alt", {24'd0, count_f1}, 32'd3);
        check("count_f2_alt", {24'd0, count_f2}, 32'd3);

        $display("[TB] step: only f2 non-empty");
        empty_f1 = 1'b1;
        repeat (4) cycle();
        check("count_f2_only", {24'd0, count_f2}, 32'd7);

        $display("[TB] step: almost_full_f1 pulse, pause/write");
        empty_f2 = 1'b1; dest_ready = 1'b0; valid_in = 1'b1;
        cycle(); cycle();
        almost_full_f1 = 1'b1;
        cycle(); cycle();
        almost_full_f1 = 1'b0;
        cycle(); cycle();

        $display("[TB] step: init and non-empty together, INIT wins");
        init = 1'b1; empty_f1 = 1'b0; dest_ready = 1'b1;
        umbral_af_in = 3'd6; umbral_ae_in = 3'd4;
        cycle(); cycle();
        init = 1'b0;
        cycle();

        $display("[TB] step: f1 grants up to saturation");
        repeat (256) cycle();
        check("count_f1_sat", {24'd0, count_f1}, 32'd255);

        $display("[TB] step: async reset mid-grant");
        @(negedge clk);
        check("pre_reset_grant", {31'd0, read_f1}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_read_f1", {31'd0, read_f1}, 32'd0);
        check("rst_read_f2", {31'd0, read_f2}, 32'd0);
        check("rst_write", {31'd0, write}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd0);
        check("rst_pause", {31'd0, pause}, 32'd0);
        check("rst_count_f1", {24'd0, count_f1}, 32'd0);
        check("rst_count_f2", {24'd0, count_f2}, 32'd0);
        check("rst_umbral_af", {29'd0, umbral_af}, 32'd3);
        check("rst_umbral_ae", {29'd0, umbral_ae}, 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        cycle();

        $display("[TB] step: release with f1 non-empty, earliest ACTIVE");
        reset = 1'b0;
        cycle(); cycle(); cycle(); cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/disp2_flow_ctrl.md
# disp2_flow_ctrl

Flow-control and read scheduler for the two-output dispatcher stage of the adaptive PCIe switch. It gates writes into the dispatcher's two output FIFOs from their almost-full flags and shares a single downstream port between the two FIFOs with round-robin read grants. It also owns the FIFO threshold configuration, exposed through an INIT state.

## Interface
Parameters:
- DEPTH_W, 3: width of FIFO threshold values.
- AF_DEF, 3: almost-full threshold loaded at reset.
- AE_DEF, 1: almost-empty threshold loaded at reset.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- init  in  1  request to (re)load thresholds.
- umbral_af_in  in  DEPTH_W  almost-full threshold to load.
- umbral_ae_in  in  DEPTH_W  almost-empty threshold to load.
- valid_in  in  1  upstream holds a word for the dispatcher.
- empty_f1, empty_f2  in  1  FIFO empty flags.
- almost_full_f1, almost_full_f2  in  1  FIFO almost-full flags.
- dest_ready  in  1  downstream accepts one word this cycle.
- write  out  1  write enable to the dispatcher FIFOs.
- read_f1, read_f2  out  1  one-hot read grants.
- pause  out  1  backpressure to upstream.
- umbral_af, umbral_ae  out  DEPTH_W  active thresholds, driven to the FIFOs.
- state  out  2  current FSM state.
- idle  out  1  high in IDLE.
- count_f1, count_f2  out  8  granted-read counters.

## Operation
- FSM encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- RESET:
  - Entered asynchronously on reset.
  - Leaves to INIT on the first clk edge after reset deasserts.
- INIT:
  - umbral_af/umbral_ae register umbral_*_in every cycle.
  - Leaves when init=0: to IDLE if both FIFOs are empty, else to ACTIVE.
- IDLE:
  - idle=1.
  - init=1 goes to INIT (highest priority).
  - Otherwise, either FIFO non-empty goes to ACTIVE.
- ACTIVE:
  - init=1 goes to INIT.
  - empty_f1 && empty_f2 goes to IDLE.
- Read grants (combinational, ACTIVE only, require dest_ready):
  - Only one FIFO non-empty: grant that FIFO.
  - Both non-empty: grant the FIFO selected by the rr pointer.
  - At most one grant per cycle; no grant in RESET, INIT or IDLE.
- rr pointer:
  - Reset value points to f1.
  - After any grant it points to the other FIFO; otherwise it holds.
- pause is registered:
  - Next cycle = almost_full_f1 | almost_full_f2.
  - No hysteresis.
- write = valid_in & ~pause & (state==IDLE | state==ACTIVE).
- count_fN:
  - Increments by 1 on each cycle with read_fN=1.
  - Saturates at 255; does not wrap.
  - Cleared only by reset; INIT does not clear it.

## Timing
- Reset values:
  - state=0; write, read_f1, read_f2, pause, idle all 0.
  - umbral_af=AF_DEF, umbral_ae=AE_DEF.
  - count_f1=count_f2=0; rr points to f1.
- Earliest ACTIVE: 2 edges after reset release (RESET→INIT→ACTIVE) when init=0 and a FIFO is non-empty.
- Grant latency: 0 cycles from dest_ready and empty flags (combinational). Counters and the rr pointer update on the same edge that consumes the grant.
- pause latency: 1 cycle after an almost_full change. write therefore drops 1 cycle after almost_full rises.
- Simultaneous events:
  - init=1 while a FIFO becomes non-empty: INIT wins.
  - Both FIFOs drain on the last granted read: the next state is IDLE and the grant in that cycle still counts.
- reset asserted mid-grant: read_fN and write drop immediately (asynchronously); thresholds revert to defaults.

## Structure
- Shared package disp2_pkg holds:
  - State encodings ST_RESET/ST_INIT/ST_IDLE/ST_ACTIVE.
  - Defaults for DEPTH_W, AF_DEF, AE_DEF.
  - COUNT_W=8.
- One natural sub-module: rr_arb2, the two-requester round-robin arbiter (req[1:0], ready → one-hot gnt, pointer register). The FSM, threshold registers, pause logic and counters stay in the top.

## Test plan
- Reset then release with init=0 and both FIFOs empty → state goes 0→1→2, idle=1, umbral_af=3, umbral_ae=1.
- init=1 with umbral_af_in=5, umbral_ae_in=2, then init=0 → umbral_af=5, umbral_ae=2 while state=INIT; state returns to IDLE.
- Both FIFOs non-empty, dest_ready=1 for 6 cycles → grants f1,f2,f1,f2,f1,f2; count_f1=count_f2=3.
- Only f2 non-empty for 4 cycles with dest_ready=1 → read_f2=1 every cycle; read_f1=0; count_f2 rises by 4.
- almost_full_f1 pulsed high for 2 cycles with valid_in=1 → pause=1 for 2 cycles starting 1 cycle later; write=0 for exactly those cycles.
- reset asserted mid-ACTIVE after count_f1 reaches 255 → all outputs return to reset values immediately and count_f1=0. Before reset, count_f1 holds 255 under further grants.
